// File: rtl/mat_vec_stream_io_if.sv
// Stream bundle for mat_vec_stream_io.
//
// It groups the element-wise input stream and the result output stream.
//   s_data/s_valid/s_ready : input elements, valid/ready handshake
//   m_data/m_valid/m_ready : output result elements, valid/ready handshake
// Modports:
//   slave  : the stream block itself (consumes s_*, produces m_*)
//   master : the environment around it (produces s_*, consumes m_*)
interface mat_vec_stream_io_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/mat_vec_stream_io.sv
// Streaming front/back end for mat_vec_mul.
//
// The block collects matrix elements (row-major), then vector elements, from
// the input stream. These are held in registers that drive the multiplier's
// parallel mat/vec inputs. It waits out MUL_LATENCY, captures the parallel res
// array and then sends the results one at a time on the output stream.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   io       stream bundle (slave view): s_data/s_valid/s_ready in,
//            m_data/m_valid/m_ready out
//   hold_mat (only with MAT_VEC_MAT_HOLD_EN) keep the matrix for the next
//            transaction when high on the final output transfer
//   mat      matrix register [MAT_ROW][MAT_COL] -> mat_vec_mul.mat
//   vec      vector register [MAT_COL]          -> mat_vec_mul.vec
//   res      result array [MAT_ROW]             <- mat_vec_mul.res
//   busy     low only when idle in LOAD_MAT with nothing loaded
//
// Optional feature macro: MAT_VEC_MAT_HOLD_EN (adds hold_mat).
module mat_vec_stream_io #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAT_ROW     = 4,
  parameter int MAT_COL     = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  mat_vec_stream_io_if.slave                            io,
`ifdef MAT_VEC_MAT_HOLD_EN
  input  logic                                          hold_mat,
`endif
  output logic [MAT_ROW-1:0][MAT_COL-1:0][DATA_WIDTH-1:0] mat,
  output logic [MAT_COL-1:0][DATA_WIDTH-1:0]              vec,
  input  logic [MAT_ROW-1:0][DATA_WIDTH-1:0]              res,
  output logic                                          busy
);

  localparam int RW = (MAT_ROW > 1) ? $clog2(MAT_ROW) : 1;
  localparam int CW = (MAT_COL > 1) ? $clog2(MAT_COL) : 1;
  localparam int LW = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(MAT_ROW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(MAT_COL - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MUL_LATENCY);

  typedef enum logic [1:0] {
    LOAD_MAT,
    LOAD_VEC,
    WAIT,
    SEND
  } state_t;

  state_t                  state_reg, state_next;
  // row_reg is the matrix row while loading and the result index while sending;
  // both uses start at 0, so it is cleared on every hand-over.
  logic [RW-1:0]           row_reg, row_next;
  logic [CW-1:0]           col_reg, col_next;
  logic [CW-1:0]           idx_reg, idx_next;
  logic [LW-1:0]           lat_reg, lat_next;
  logic [DATA_WIDTH-1:0]   res_buf_reg [MAT_ROW];

  logic                    s_fire;
  logic                    m_fire;
  logic                    mat_we;
  logic                    vec_we;
  logic                    res_cap;
  logic                    hold_sel;

`ifdef MAT_VEC_MAT_HOLD_EN
  assign hold_sel = hold_mat;
`else
  assign hold_sel = 1'b0;
`endif

  // Handshake outputs are decoded from state only, never from valid/ready.
  assign io.s_ready = (state_reg == LOAD_MAT) || (state_reg == LOAD_VEC);
  assign io.m_valid = (state_reg == SEND);
  assign io.m_data  = (state_reg == SEND) ? res_buf_reg[row_reg] : '0;
  assign busy       = !((state_reg == LOAD_MAT) && (row_reg == '0) && (col_reg == '0));

  assign s_fire = io.s_valid && io.s_ready;
  assign m_fire = io.m_valid && io.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD_MAT;
      row_reg   <= '0;
      col_reg   <= '0;
      idx_reg   <= '0;
      lat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      idx_reg   <= idx_next;
      lat_reg   <= lat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    idx_next   = idx_reg;
    lat_next   = lat_reg;
    mat_we     = 1'b0;
    vec_we     = 1'b0;
    res_cap    = 1'b0;
    case (state_reg)
      LOAD_MAT: begin
        if (s_fire) begin
          mat_we = 1'b1;
          if (col_reg == COL_LAST) begin
            col_next = '0;
            if (row_reg == ROW_LAST) begin
              row_next   = '0;
              idx_next   = '0;
              state_next = LOAD_VEC;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      LOAD_VEC: begin
        if (s_fire) begin
          vec_we = 1'b1;
          if (idx_reg == COL_LAST) begin
            idx_next   = '0;
            lat_next   = LAT_LOAD;
            state_next = WAIT;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      WAIT: begin
        // Capture happens on the edge where the counter already reads 0,
        // giving MUL_LATENCY+1 edges between the last vec write and capture.
        if (lat_reg == '0) begin
          res_cap    = 1'b1;
          row_next   = '0;
          state_next = SEND;
        end else begin
          lat_next = lat_reg - 1'b1;
        end
      end
      SEND: begin
        if (m_fire) begin
          if (row_reg == ROW_LAST) begin
            row_next   = '0;
            idx_next   = '0;
            state_next = hold_sel ? LOAD_VEC : LOAD_MAT;
          end else begin
            row_next = row_reg + 1'b1;
          end
        end
      end
      default: state_next = LOAD_MAT;
    endcase
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < MAT_ROW; gi++) begin : g_row
      for (gj = 0; gj < MAT_COL; gj++) begin : g_col
        always_ff @(posedge clk) begin
          if (rst) begin
            mat[gi][gj] <= '0;
          end else if (mat_we && (row_reg == RW'(gi)) && (col_reg == CW'(gj))) begin
            mat[gi][gj] <= io.s_data;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          res_buf_reg[gi] <= '0;
        end else if (res_cap) begin
          res_buf_reg[gi] <= res[gi];
        end
      end
    end

    for (gi = 0; gi < MAT_COL; gi++) begin : g_vec
      always_ff @(posedge clk) begin
        if (rst) begin
          vec[gi] <= '0;
        end else if (vec_we && (idx_reg == CW'(gi))) begin
          vec[gi] <= io.s_data;
        end
      end
    end
  endgenerate

endmodule

// File: doc/mat_vec_stream_io.md
Name: mat_vec_stream_io

Overview:
Streaming front/back end for the matrix-vector multiplier (mat_vec_mul).
- Accepts matrix and vector elements one at a time on a valid/ready input stream.
- Holds them in registers that drive the multiplier's parallel mat/vec inputs.
- Waits out the multiplier latency, captures its parallel res array and serialises it onto a valid/ready output stream.
- Is the element-wise writer/reader that pairs with the multiplier's parallel interface.

Parameters:
DATA_WIDTH, 8, element width; must match mat_vec_mul.
MAT_ROW, 4, matrix rows, which is also the result length.
MAT_COL, 4, matrix columns, which is also the vector length.
MUL_LATENCY, 1, cycles from stable mat/vec to valid res (mat_vec_mul registers once).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
s_data  input  DATA_WIDTH  input element.
s_valid  input  1  input element valid.
s_ready  output  1  block can accept an element.
mat  output  DATA_WIDTH x [MAT_ROW][MAT_COL]  matrix register, drives mat_vec_mul.mat.
vec  output  DATA_WIDTH x [MAT_COL]  vector register, drives mat_vec_mul.vec.
res  input  DATA_WIDTH x [MAT_ROW]  result array from mat_vec_mul.res.
m_data  output  DATA_WIDTH  output result element.
m_valid  output  1  output element valid.
m_ready  input  1  downstream accepts an element.
busy  output  1  high in every state except LOAD_MAT with no element yet loaded.

Behaviour:
- Clocking and reset: single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: state=LOAD_MAT; element index=0; mat, vec, result buffer all 0; s_ready=1; m_valid=0; m_data=0; busy=0.
- Element transfer rules:
  - Input transfer occurs when s_valid&&s_ready at a rising edge.
  - Output transfer occurs when m_valid&&m_ready at a rising edge.
- Input order: row-major matrix first, i.e. mat[0][0], mat[0][1] ... mat[MAT_ROW-1][MAT_COL-1]. Then vec[0] .. vec[MAT_COL-1].
- LOAD_MAT:
  - s_ready=1.
  - Each transfer writes mat[r][c] and advances c, wrapping to 0 and incrementing r.
  - On the transfer of the last matrix element, go to LOAD_VEC with the index cleared.
- LOAD_VEC:
  - s_ready=1.
  - Each transfer writes vec[k].
  - On the transfer of vec[MAT_COL-1], go to WAIT and load the latency counter with MUL_LATENCY.
- WAIT:
  - s_ready=0.
  - mat/vec are held stable.
  - The counter decrements each cycle. When it is 0, capture res[0..MAT_ROW-1] into the internal result buffer on that edge and go to SEND with the index at 0.
  - Net effect: res is sampled MUL_LATENCY+1 edges after the last vector transfer.
- SEND:
  - s_ready=0, m_valid=1, m_data=buffer[idx].
  - Each output transfer advances idx.
  - Transfer of idx=MAT_ROW-1 returns to LOAD_MAT, with m_valid low the next cycle.
  - m_data is stable while m_valid&&!m_ready.
- Input gaps: s_valid low stalls loading with no state change.
- Backpressure: m_ready low stalls SEND indefinitely.
- Arithmetic: the block does none. Results are passed through exactly as produced; mat_vec_mul truncates to DATA_WIDTH (mod 2^DATA_WIDTH).
- s_ready is a registered/state-decoded signal with no combinational dependence on s_valid. m_valid likewise does not depend on m_ready.
- Reset mid-operation: any state returns to reset values on the next edge. Partially loaded data is discarded and zeroed, and any pending output is dropped (m_valid=0).
- Data presented while s_ready=0 is ignored and is not captured later.
- mat/vec retain their last values after SEND until overwritten by a new load.

Optional Feature:
Macro: MAT_VEC_MAT_HOLD_EN.
- Defined:
  - Adds input port hold_mat (1 bit).
  - If hold_mat=1 on the edge of the final SEND transfer, the next state is LOAD_VEC, not LOAD_MAT. The matrix is retained and only MAT_COL vector elements are expected.
  - With hold_mat=0, behaviour is as in Behaviour.
  - hold_mat is ignored in all other cycles.
  - Reset still clears mat.
- Undefined: the port is absent and every transaction loads the full matrix.

Test Plan:
- Identity: MAT_ROW=MAT_COL=4, load the 4x4 identity matrix, then vec=1,2,3,4, with m_ready=1 -> m_data 1,2,3,4 on consecutive cycles. s_ready is 0 from the cycle after vec[3] until after the 4th output transfer.
- Wrap-around: all mat elements=16, vec elements=16 -> each result (16*16*4) mod 256 = 0. Second run with mat all 1, vec all 63 -> each result 252.
- Backpressure and gaps:
  - Toggle s_valid pseudo-randomly during loading; hold m_ready=0 for 5 cycles in SEND, then toggle it.
  - Required response: mat=[[1,2,3,4]...] rows repeated and vec=1,1,1,1 -> every result 10.
  - m_data does not change while stalled, and no element is duplicated or lost.
- Reset mid-load: rst high for 1 cycle after 7 matrix elements -> mat/vec all 0, state LOAD_MAT. A fresh full load then gives correct results, with no leftover elements from before reset.
- Back-to-back: two transactions with no idle cycle; the second uses mat rows all 2 and vec=1,2,3,4 -> results 20,20,20,20. The first transaction's results are unaffected.
- MAT_VEC_MAT_HOLD_EN:
  - hold_mat=1 at the final SEND transfer, then load only vec=4,3,2,1 on the identity matrix -> outputs 4,3,2,1.
  - With hold_mat=0 -> the block expects 16 matrix elements first.
